cpu_phase_seq: RTL and testbench
================================

Name: cpu_phase_seq

Overview:
Multi-cycle instruction sequencer for the CPU core. Drives the one-hot phase vector `start[3:0]` (fetch, decode, execute, write) that enables the fetch/decode/execute/write stages. Owns the architectural PC and waits on instruction/data memory handshakes with a timeout. Converts the write stage's `reg_update` and `pc_update` results into a register-file write strobe and a PC commit, and counts retired instructions.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
PC_STEP, 4, sequential PC increment (unsigned, added modulo 2^32).
CNT_W, 32, width of the retired-instruction counter.
TIMEOUT, 16, maximum cycles spent waiting for a memory ready; 0 disables the timeout.

Ports:
clk  input  1  core clock; all state updates on the rising edge.
rst_n  input  1  synchronous active-low reset.
run  input  1  level; 1 allows new instructions to start.
imem_ready  input  1  instruction memory data valid this cycle.
dmem_ready  input  1  data memory access complete this cycle.
mem_op  input  1  decoded instruction needs data memory; sampled in EXEC.
halt  input  1  decoded halt instruction; sampled in DECODE.
reg_update  input  1  write-stage request to write the register file.
pc_update  input  1  write-stage request to load `pc_new`.
pc_new  input  32  branch/jump target from the write stage.
start  output  4  one-hot phase: [0]=FETCH, [1]=DECODE, [2]=EXEC, [3]=WRITE; 4'b0000 in other states.
pc  output  32  current architectural PC.
fetch_req  output  1  instruction memory request.
dmem_req  output  1  data memory request.
reg_we  output  1  register-file write strobe.
busy  output  1  1 in any state except IDLE, HALT and ERROR.
halted  output  1  sticky; halt instruction reached.
err  output  1  sticky; memory timeout occurred.
retire_cnt  output  CNT_W  count of completed instructions.

Behaviour:
- Reset (rst_n=0 at a rising edge), values from the next cycle:
  - state=IDLE, pc=RESET_PC, retire_cnt=0, halted=0, err=0, wait counter=0.
  - All combinational outputs evaluate to 0.
- Reset has priority over everything and aborts any phase mid-instruction; no PC commit and no retire occur.
- States: IDLE, FETCH, DECODE, EXEC, WRITE, HALT, ERROR. `start` is decoded from the state and is registered, so it is glitch-free.
- IDLE: if run=1, go to FETCH.
- FETCH:
  - fetch_req=1.
  - If imem_ready=1, go to DECODE.
  - Else increment the wait counter. When TIMEOUT!=0 and the counter reaches TIMEOUT-1 without ready, go to ERROR.
- DECODE: if halt=1, go to HALT (pc unchanged, no retire); else go to EXEC.
- EXEC, mem_op=0: one cycle, then WRITE.
- EXEC, mem_op=1:
  - dmem_req=1 until dmem_ready=1, then WRITE.
  - Same timeout rule as FETCH. mem_op must stay stable while waiting.
- WRITE (exactly one cycle):
  - reg_we = reg_update (combinational, WRITE only).
  - At the end of the cycle: pc <= pc_update ? pc_new : pc+PC_STEP; retire_cnt += 1 (wraps).
  - Next state is FETCH if run=1, else IDLE.
- The wait counter clears on entering FETCH or EXEC. imem_ready and dmem_ready are ignored outside their own wait phases.
- run=0 mid-instruction: the current instruction completes through WRITE, then the block stops in IDLE.
- HALT and ERROR are sticky until reset: start=0, busy=0, no requests. halted=1 in HALT; err=1 in ERROR.
- Minimum instruction latency is 4 cycles (ready in the same cycle as the request).

Test Plan:
- Reset then run=1, imem_ready=1, mem_op=0, reg_update=1 for 3 instructions:
  - start cycles 0001,0010,0100,1000 with period 4.
  - reg_we pulses 3 times; pc = 0x0, 0x4, 0x8, 0xC; retire_cnt=3.
- Branch: pc_update=1, pc_new=0x100 in WRITE -> next FETCH has pc=0x100, reg_we=0 when reg_update=0.
- Memory wait: mem_op=1, dmem_ready asserted after 5 cycles -> EXEC lasts 6 cycles with dmem_req high throughout, then WRITE; retire_cnt increments by 1.
- Timeout: TIMEOUT=16, imem_ready held 0 -> ERROR after 16 FETCH cycles; err=1, start=0, busy=0; stays there until reset.
- halt=1 in DECODE -> HALT; halted=1, pc unchanged, retire_cnt unchanged, no reg_we.
- Deassert run during EXEC -> WRITE completes, then IDLE. Assert rst_n=0 during a FETCH wait -> pc=RESET_PC, state IDLE, counters 0.

Source files
------------

// File: rtl/cpu_phase_seq.sv
`default_nettype none
// ============================================================================
// Module   : cpu_phase_seq
// Brief    : Multi-cycle fetch/decode/execute/write sequencer with PC, retire
//            counter and memory-handshake timeout.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_phase_seq #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4,
    parameter int          CNT_W    = 32,
    parameter int          TIMEOUT  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    input  logic             mem_op,
    input  logic             halt,
    input  logic             reg_update,
    input  logic             pc_update,
    input  logic [31:0]      pc_new,
    output logic [3:0]       start,
    output logic [31:0]      pc,
    output logic             fetch_req,
    output logic             dmem_req,
    output logic             reg_we,
    output logic             busy,
    output logic             halted,
    output logic             err,
    output logic [CNT_W-1:0] retire_cnt
);

    localparam int c_WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_FETCH  = 3'd1;
    localparam logic [2:0] c_ST_DECODE = 3'd2;
    localparam logic [2:0] c_ST_EXEC   = 3'd3;
    localparam logic [2:0] c_ST_WRITE  = 3'd4;
    localparam logic [2:0] c_ST_HALT   = 3'd5;
    localparam logic [2:0] c_ST_ERROR  = 3'd6;

    logic [2:0]          r_state;
    logic [2:0]          w_state_nxt;
    logic [3:0]          r_start;
    logic [3:0]          w_start_nxt;
    logic [31:0]         r_pc;
    logic [CNT_W-1:0]    r_retire;
    logic [c_WAIT_W-1:0] r_wait;
    logic                w_timeout;
    logic                w_waiting;

    assign w_timeout = (TIMEOUT != 0) && (r_wait == c_WAIT_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_start_nxt = 4'b0000;
        case (r_state)
            c_ST_IDLE: begin
                if (run) w_state_nxt = c_ST_FETCH;
            end
            c_ST_FETCH: begin
                if (imem_ready)     w_state_nxt = c_ST_DECODE;
                else if (w_timeout) w_state_nxt = c_ST_ERROR;
            end
            c_ST_DECODE: begin
                w_state_nxt = halt ? c_ST_HALT : c_ST_EXEC;
            end
            c_ST_EXEC: begin
                if (!mem_op || dmem_ready) w_state_nxt = c_ST_WRITE;
                else if (w_timeout)        w_state_nxt = c_ST_ERROR;
            end
            c_ST_WRITE: begin
                w_state_nxt = run ? c_ST_FETCH : c_ST_IDLE;
            end
            c_ST_HALT:  w_state_nxt = c_ST_HALT;
            c_ST_ERROR: w_state_nxt = c_ST_ERROR;
            default:    w_state_nxt = c_ST_IDLE;
        endcase
        // Phase vector is decoded from the next state so it can be registered.
        case (w_state_nxt)
            c_ST_FETCH:  w_start_nxt = 4'b0001;
            c_ST_DECODE: w_start_nxt = 4'b0010;
            c_ST_EXEC:   w_start_nxt = 4'b0100;
            c_ST_WRITE:  w_start_nxt = 4'b1000;
            default:     w_start_nxt = 4'b0000;
        endcase
    end

    // Staying in FETCH or EXEC can only mean a memory wait.
    assign w_waiting = (w_state_nxt == r_state) &&
                       ((r_state == c_ST_FETCH) || (r_state == c_ST_EXEC));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= c_ST_IDLE;
            r_start  <= 4'b0000;
            r_pc     <= RESET_PC;
            r_retire <= '0;
            r_wait   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_start <= w_start_nxt;
            r_wait  <= w_waiting ? r_wait + c_WAIT_W'(1) : '0;
            if (r_state == c_ST_WRITE) begin
                r_pc     <= pc_update ? pc_new : r_pc + PC_STEP;
                r_retire <= r_retire + CNT_W'(1);
            end
        end
    end

    assign start      = r_start;
    assign pc         = r_pc;
    assign retire_cnt = r_retire;
    assign fetch_req  = (r_state == c_ST_FETCH);
    assign dmem_req   = (r_state == c_ST_EXEC) && mem_op;
    assign reg_we     = (r_state == c_ST_WRITE) && reg_update;
    assign busy       = (r_state != c_ST_IDLE) && (r_state != c_ST_HALT) &&
                        (r_state != c_ST_ERROR);
    assign halted     = (r_state == c_ST_HALT);
    assign err        = (r_state == c_ST_ERROR);

endmodule
`default_nettype wire

// File: tb/tb_cpu_phase_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_phase_seq
// Brief    : Scoreboard bench for cpu_phase_seq with randomized instructions.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_phase_seq;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic        imem_ready;
    logic        dmem_ready;
    logic        mem_op;
    logic        halt;
    logic        reg_update;
    logic        pc_update;
    logic [31:0] pc_new;
    logic [3:0]  start;
    logic [31:0] pc;
    logic        fetch_req;
    logic        dmem_req;
    logic        reg_we;
    logic        busy;
    logic        halted;
    logic        err;
    logic [31:0] retire_cnt;

    cpu_phase_seq #(
        .RESET_PC (32'h0000_0000),
        .PC_STEP  (32'd4),
        .CNT_W    (32),
        .TIMEOUT  (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .imem_ready (imem_ready),
        .dmem_ready (dmem_ready),
        .mem_op     (mem_op),
        .halt       (halt),
        .reg_update (reg_update),
        .pc_update  (pc_update),
        .pc_new     (pc_new),
        .start      (start),
        .pc         (pc),
        .fetch_req  (fetch_req),
        .dmem_req   (dmem_req),
        .reg_we     (reg_we),
        .busy       (busy),
        .halted     (halted),
        .err        (err),
        .retire_cnt (retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        we;
        int          lat;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    bit          mon_en   = 1'b0;
    logic [31:0] model_pc;
    logic [31:0] model_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops an expectation on every WRITE phase and checks invariants.
    int          cyc     = 0;
    int          fetch_t = 0;
    logic [3:0]  prev_start = 4'b0000;
    always @(negedge clk) begin
        cyc++;
        if (mon_en) begin
            if (start == 4'b0001 && prev_start != 4'b0001) fetch_t = cyc;
            if (start != prev_start && start != 4'b0000 && prev_start != 4'b0000)
                check("phase_order", {28'd0, start}, {28'd0, prev_start[2:0], prev_start[3]});
            if (busy !== (start != 4'b0000)) check("busy_vs_start", {31'd0, busy}, {31'd0, start != 4'b0000});
            if (fetch_req !== (start == 4'b0001)) check("fetch_req", {31'd0, fetch_req}, {31'd0, start == 4'b0001});
            if (dmem_req !== (start == 4'b0100 && mem_op)) check("dmem_req", {31'd0, dmem_req}, {31'd0, start == 4'b0100 && mem_op});
            if (start != 4'b1000 && reg_we !== 1'b0) check("reg_we_idle", {31'd0, reg_we}, 32'd0);
            if (start == 4'b1000) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_write", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("wr_pc", pc, e.pc);
                    check("wr_reg_we", {31'd0, reg_we}, {31'd0, e.we});
                    check("wr_retire_cnt", retire_cnt, e.cnt);
                    check("wr_latency", cyc - fetch_t + 1, e.lat);
                end
            end
        end
        prev_start = start;
    end

    // One instruction starting in FETCH; returns in the cycle after WRITE.
    task automatic run_instr(input int di, input bit mem, input int dm, input bit ru,
                             input bit pu, input logic [31:0] pn, input bit stop);
        exp_t e;
        e.pc  = model_pc;
        e.we  = ru;
        e.lat = 4 + di + (mem ? dm : 0);
        e.cnt = model_cnt;
        sb.push_back(e);
        model_pc  = pu ? pn : model_pc + 32'd4;
        model_cnt = model_cnt + 32'd1;
        for (int k = 0; k <= di; k++) begin
            imem_ready = (k == di);
            dmem_ready = 1'($urandom);
            step();
        end
        imem_ready = 1'($urandom);
        dmem_ready = 1'($urandom);
        halt       = 1'b0;
        mem_op     = mem;
        step();
        if (stop) run = 1'b0;
        if (mem) begin
            for (int k = 0; k <= dm; k++) begin
                dmem_ready = (k == dm);
                imem_ready = 1'($urandom);
                step();
            end
        end else begin
            dmem_ready = 1'($urandom);
            step();
        end
        reg_update = ru;
        pc_update  = pu;
        pc_new     = pn;
        imem_ready = 1'($urandom);
        dmem_ready = 1'($urandom);
        step();
        reg_update = 1'b0;
        pc_update  = 1'b0;
        mem_op     = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        run   = 1'b0;
        step();
        step();
        model_pc  = 32'h0;
        model_cnt = 32'h0;
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        rst_n = 1'b0; run = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
        mem_op = 1'b0; halt = 1'b0; reg_update = 1'b0; pc_update = 1'b0; pc_new = 32'h0;
        do_reset();
        mon_en = 1'b1;
        check("rst_pc", pc, 32'h0);
        check("rst_retire", retire_cnt, 32'h0);
        check("rst_outs", {24'd0, start, fetch_req, dmem_req, reg_we, busy}, 32'h0);
        check("rst_flags", {30'd0, halted, err}, 32'h0);

        run = 1'b1;
        step();
        for (int i = 0; i < 3; i++) run_instr(0, 1'b0, 0, 1'b1, 1'b0, 32'h0, 1'b0);
        check("pc_after_3", pc, 32'hC);
        run_instr(0, 1'b0, 0, 1'b0, 1'b1, 32'h100, 1'b0);
        check("branch_pc", pc, 32'h100);
        run_instr(0, 1'b1, 5, 1'b1, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 40; i++)
            run_instr($urandom_range(0, 3), 1'($urandom), $urandom_range(0, 6), 1'($urandom),
                      ($urandom_range(0, 3) == 0), $urandom & 32'hFFFF_FFFC, (i == 39));
        step();
        check("stop_idle", {27'd0, start, busy}, 32'h0);
        check("stop_pc", pc, model_pc);
        check("stop_retire", retire_cnt, model_cnt);

        // Reset in the middle of a fetch wait.
        run = 1'b1;
        imem_ready = 1'b0;
        step();
        step(); step(); step();
        rst_n = 1'b0;
        step();
        check("midrst_pc", pc, 32'h0);
        check("midrst_retire", retire_cnt, 32'h0);
        check("midrst_idle", {27'd0, start, busy}, 32'h0);
        rst_n = 1'b1;
        model_pc = 32'h0;
        model_cnt = 32'h0;
        step();
        run_instr(1, 1'b0, 0, 1'b1, 1'b0, 32'h0, 1'b0);
        run_instr(0, 1'b1, 2, 1'b0, 1'b0, 32'h0, 1'b0);

        // Halt reached in DECODE.
        imem_ready = 1'b1;
        step();
        halt = 1'b1;
        step();
        halt = 1'b0;
        imem_ready = 1'b0;
        step(); step(); step();
        check("halt_flag", {30'd0, halted, err}, 32'h2);
        check("halt_idle", {27'd0, start, busy}, 32'h0);
        check("halt_pc", pc, 32'h8);
        check("halt_retire", retire_cnt, 32'd2);

        // Fetch timeout.
        do_reset();
        run = 1'b1;
        step();
        n = 0;
        while (start == 4'b0001 && n < 40) begin
            n++;
            step();
        end
        check("fetch_timeout_cycles", n, 16);
        step(); step();
        check("fetch_timeout_err", {30'd0, halted, err}, 32'h1);
        check("fetch_timeout_idle", {27'd0, start, busy}, 32'h0);

        // Data memory timeout.
        do_reset();
        run = 1'b1;
        step();
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        mem_op = 1'b1;
        step();
        n = 0;
        while (start == 4'b0100 && n < 40) begin
            n++;
            step();
        end
        mem_op = 1'b0;
        check("exec_timeout_cycles", n, 16);
        check("exec_timeout_err", {30'd0, halted, err}, 32'h1);
        check("exec_timeout_retire", retire_cnt, 32'h0);

        check("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
